// File: rtl/maze_pkg.sv
// maze_pkg: headings, play-field geometry and the constant wall map for maze sprites
package maze_pkg;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int SPRITE = 16;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_ROWS = SCR_H >> TILE_SHIFT;
  localparam int MAP_COLS = SCR_W >> TILE_SHIFT;
  // bit c of a row pattern is column c; the map is borders plus a bar on row 15, cols 10..29
  localparam logic [39:0] FULL_ROW = '1;
  localparam logic [39:0] SIDE_ROW = 40'h80_0000_0001;
  localparam logic [39:0] BAR_ROW = 40'h80_3FFF_FC01;
  function automatic logic wall_at(input logic [4:0] row, input logic [5:0] col);
    logic [39:0] r;
    r = (row == 5'd0 || row == 5'(MAP_ROWS - 1)) ? FULL_ROW : row == 5'd15 ? BAR_ROW : SIDE_ROW;
    return (row >= 5'(MAP_ROWS) || col >= 6'(MAP_COLS)) ? 1'b1 : r[col];
  endfunction
endpackage

// File: rtl/clk_counter.sv
// clk_counter: free-running 32-bit divider; consumers tap individual bits as slow clocks
module clk_counter (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] count
);
  always_ff @(posedge clk)
    if (!rst) count <= '0;
    else count <= count + 32'd1;
endmodule

// File: rtl/maze_collision_unit.sv
// maze_collision_unit: registered legality of a one-pixel sprite step against the maze walls
module maze_collision_unit
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  PacX,
  input  logic [8:0]  PacY,
  input  logic [1:0]  state,
  output logic        result,
  output logic [31:0] clkdiv
);
  localparam int S = SPRITE - 1;
  logic [10:0] nx, ax, bx;
  logic [9:0] ny, ay, by;
  logic under, blocked;
  assign nx = state == DIR_LEFT ? {1'b0, PacX} - 11'd1 : state == DIR_RIGHT ? {1'b0, PacX} + 11'd1 : {1'b0, PacX};
  assign ny = state == DIR_UP ? {1'b0, PacY} - 10'd1 : state == DIR_DOWN ? {1'b0, PacY} + 10'd1 : {1'b0, PacY};
  assign under = (state == DIR_LEFT && PacX == '0) || (state == DIR_UP && PacY == '0);
  // probe a and b are the two corners on the leading edge of the next box
  assign ax = state == DIR_RIGHT ? nx + 11'(S) : nx;
  assign ay = state == DIR_DOWN ? ny + 10'(S) : ny;
  assign bx = state == DIR_LEFT ? nx : nx + 11'(S);
  assign by = state == DIR_UP ? ny : ny + 10'(S);
  assign blocked = under || ax >= 11'(SCR_W) || bx >= 11'(SCR_W) || ay >= 10'(SCR_H) || by >= 10'(SCR_H)
                   || wall_at(ay[8:4], ax[9:4]) || wall_at(by[8:4], bx[9:4]);
  always_ff @(posedge clk)
    if (!rst) result <= 1'b0;
    else result <= ~blocked;
  clk_counter u_div (.clk(clk), .rst(rst), .count(clkdiv));
endmodule

// File: tb/tb_maze_collision_unit.sv
// tb_maze_collision_unit: directed vectors with hand-computed step legality and divider counts
module tb_maze_collision_unit;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] PacX;
  logic [8:0] PacY;
  logic [1:0] state;
  logic result;
  logic [31:0] clkdiv;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_div = 0;

  maze_collision_unit dut (.clk(clk), .rst(rst), .PacX(PacX), .PacY(PacY), .state(state),
                           .result(result), .clkdiv(clkdiv));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input int x, input int y, input logic [1:0] s, input logic exp);
    PacX = 10'(x);
    PacY = 9'(y);
    state = s;
    @(posedge clk);
    #1;
    exp_div = rst ? exp_div + 1 : 0;
    chk(tag, {31'd0, result}, {31'd0, exp});
    chk({tag, "_div"}, clkdiv, exp_div);
  endtask

  initial begin
    rst = 1'b0;
    step("rst0", 595, 435, 2'b10, 1'b0);
    step("rst1", 595, 435, 2'b10, 1'b0);
    step("rst2", 595, 435, 2'b10, 1'b0);
    rst = 1'b1;
    step("open_left", 595, 435, 2'b10, 1'b1);
    step("open_up", 595, 435, 2'b00, 1'b1);
    step("open_left2", 595, 435, 2'b10, 1'b1);
    step("left_border", 16, 100, 2'b10, 1'b0);
    step("up_border", 100, 16, 2'b00, 1'b0);
    step("x_underflow", 0, 100, 2'b10, 1'b0);
    step("y_underflow", 100, 0, 2'b00, 1'b0);
    step("right_623", 607, 100, 2'b11, 1'b1);
    step("right_624", 608, 100, 2'b11, 1'b0);
    step("right_625", 609, 100, 2'b11, 1'b0);
    step("bar_row14", 200, 223, 2'b01, 1'b1);
    step("bar_row15", 200, 224, 2'b01, 1'b0);
    step("bar_from_below", 200, 256, 2'b00, 1'b0);
    step("bar_col10", 150, 224, 2'b01, 1'b0);
    step("bar_col9_only", 144, 224, 2'b01, 1'b1);
    step("bottom_row28", 100, 447, 2'b01, 1'b1);
    step("bottom_row29", 100, 448, 2'b01, 1'b0);
    step("alt_l0", 16, 100, 2'b10, 1'b0);
    step("alt_r0", 16, 100, 2'b11, 1'b1);
    step("alt_l1", 16, 100, 2'b10, 1'b0);
    step("alt_r1", 16, 100, 2'b11, 1'b1);
    rst = 1'b0;
    step("midrst", 16, 100, 2'b11, 1'b0);
    rst = 1'b1;
    step("resume_r", 16, 100, 2'b11, 1'b1);
    step("resume_l", 16, 100, 2'b10, 1'b0);
    step("resume_r2", 16, 100, 2'b11, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
